// File: rtl/flash_pkg.sv
// Shared definitions for the flash page writer: command encodings and FSM states.
package flash_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_OPEN  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_CLOSE = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_UNPACK,
        ST_DRAIN,
        ST_BUSY,
        ST_FLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/flash_page_writer_if.sv
// Command/data handshake between the encoder's flash master and this writer.
interface flash_page_writer_if;
    logic [1:0]  m_cmd;
    logic        d_qual;
    logic [31:0] write_data;
    logic [3:0]  write_be;
    logic        s_halt;

    modport master (output m_cmd, d_qual, write_data, write_be, input s_halt);
    modport slave  (input m_cmd, d_qual, write_data, write_be, output s_halt);
endinterface

// File: rtl/page_ram.sv
// Page buffer: one write port, one registered read port (1-cycle latency).
module page_ram #(
    parameter  int unsigned PAGE_BYTES = 256,
    localparam int unsigned AW         = $clog2(PAGE_BYTES)
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [PAGE_BYTES];

    always_ff @(posedge clk_in) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Only the read register is reset; stored bytes are left as they are.
    always_ff @(posedge clk_in) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/flash_page_writer.sv
// Unpacks byte-enabled words MSB-first into a page buffer, streams full/final pages
// to flash one byte per cycle, then waits a fixed program time.
module flash_page_writer
    import flash_pkg::*;
#(
    parameter int unsigned PAGE_BYTES  = 256,
    parameter int unsigned PROG_CYCLES = 16,
    parameter int unsigned FADDR_WIDTH = 24
) (
    input  logic                   clk_in,
    input  logic                   rst,
    flash_page_writer_if.slave     bus,
    output logic                   fl_we,
    output logic [FADDR_WIDTH-1:0] fl_addr,
    output logic [7:0]             fl_data,
    output logic                   fl_busy,
    output logic [FADDR_WIDTH-1:0] file_bytes,
    output logic                   file_done
);
    localparam int unsigned AW = $clog2(PAGE_BYTES);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned CW = $clog2(PROG_CYCLES) + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(PAGE_BYTES);
    localparam logic [CW-1:0] PROG_LAST = CW'(PROG_CYCLES - 1);

    state_e                 state, state_next;
    logic [31:0]            word_q;
    logic [3:0]             be_left, be_after;
    logic [1:0]             lane;
    logic [7:0]             lane_byte;
    logic [FW-1:0]          fill, fill_inc;
    logic [AW-1:0]          drain_idx, rd_addr;
    logic [CW-1:0]          prog_cnt;
    logic [FADDR_WIDTH-1:0] base;
    logic                   flushing, accept, ram_we, rd_en;

    assign bus.s_halt = (state != ST_IDLE) && (state != ST_READY);
    assign accept     = bus.d_qual && !bus.s_halt && (bus.m_cmd != CMD_NOP);
    assign fill_inc   = fill + FW'(1);

    always_comb begin
        lane = 2'd0;
        if      (be_left[3]) lane = 2'd3;
        else if (be_left[2]) lane = 2'd2;
        else if (be_left[1]) lane = 2'd1;
        lane_byte = word_q[{lane, 3'b000} +: 8];
        be_after  = be_left & ~(4'b0001 << lane);
    end

    always_ff @(posedge clk_in) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // The read address leads fl_we by one cycle so registered RAM data lines up with it.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        unique case (state)
            ST_IDLE:
                if (accept && bus.m_cmd == CMD_OPEN) state_next = ST_READY;
            ST_READY:
                if (accept) begin
                    if (bus.m_cmd == CMD_WRITE && bus.write_be != 4'b0000) state_next = ST_UNPACK;
                    else if (bus.m_cmd == CMD_CLOSE)                       state_next = ST_FLUSH;
                end
            ST_UNPACK: begin
                ram_we = 1'b1;
                if (fill_inc == FILL_FULL) begin
                    state_next = ST_DRAIN;
                    rd_en      = 1'b1;
                end else if (be_after == 4'b0000) begin
                    state_next = ST_READY;
                end
            end
            ST_DRAIN:
                if (({1'b0, drain_idx} + FW'(1)) < fill) begin
                    rd_en   = 1'b1;
                    rd_addr = drain_idx + AW'(1);
                end else begin
                    state_next = ST_BUSY;
                end
            ST_BUSY:
                if (prog_cnt == PROG_LAST) begin
                    if (be_left != 4'b0000) state_next = ST_UNPACK;
                    else if (flushing)      state_next = ST_DONE;
                    else                    state_next = ST_READY;
                end
            ST_FLUSH: begin
                if (fill != '0) begin
                    state_next = ST_DRAIN;
                    rd_en      = 1'b1;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            word_q     <= '0;
            be_left    <= '0;
            fill       <= '0;
            drain_idx  <= '0;
            prog_cnt   <= '0;
            base       <= '0;
            flushing   <= 1'b0;
            fl_we      <= 1'b0;
            fl_addr    <= '0;
            fl_busy    <= 1'b0;
            file_bytes <= '0;
            file_done  <= 1'b0;
        end else begin
            fl_we     <= (state_next == ST_DRAIN);
            fl_busy   <= (state_next == ST_BUSY);
            file_done <= (state_next == ST_DONE);
            if (state_next == ST_DRAIN) begin
                fl_addr   <= base + FADDR_WIDTH'(rd_addr);
                drain_idx <= rd_addr;
            end
            if (state == ST_BUSY) prog_cnt <= prog_cnt + CW'(1);
            else                  prog_cnt <= '0;
            case (state)
                ST_IDLE:
                    if (accept && bus.m_cmd == CMD_OPEN) begin
                        fill       <= '0;
                        base       <= '0;
                        file_bytes <= '0;
                        flushing   <= 1'b0;
                    end
                ST_READY:
                    if (accept && bus.m_cmd == CMD_WRITE) begin
                        word_q  <= bus.write_data;
                        be_left <= bus.write_be;
                    end
                ST_UNPACK: begin
                    fill    <= fill_inc;
                    be_left <= be_after;
                end
                ST_BUSY:
                    if (prog_cnt == PROG_LAST) begin
                        base       <= base + FADDR_WIDTH'(fill);
                        file_bytes <= file_bytes + FADDR_WIDTH'(fill);
                        fill       <= '0;
                    end
                ST_FLUSH: flushing <= 1'b1;
                ST_DONE:  flushing <= 1'b0;
                default: ;
            endcase
        end
    end

    page_ram #(.PAGE_BYTES(PAGE_BYTES)) u_page_ram (
        .clk_in  (clk_in),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr (fill[AW-1:0]),
        .wr_data (lane_byte),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (fl_data)
    );
endmodule

// File: tb/tb_flash_page_writer.sv
// Directed + randomized bench for flash_page_writer against a byte-queue reference model.
module tb_flash_page_writer;
    import flash_pkg::*;

    localparam int unsigned PB  = 8;
    localparam int unsigned PC  = 16;
    localparam int unsigned FAW = 24;

    logic           clk_in = 1'b0;
    logic           rst = 1'b1;
    logic           fl_we, fl_busy, file_done;
    logic [FAW-1:0] fl_addr, file_bytes;
    logic [7:0]     fl_data;

    flash_page_writer_if bus ();

    flash_page_writer #(.PAGE_BYTES(PB), .PROG_CYCLES(PC), .FADDR_WIDTH(FAW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .bus        (bus),
        .fl_we      (fl_we),
        .fl_addr    (fl_addr),
        .fl_data    (fl_data),
        .fl_busy    (fl_busy),
        .file_bytes (file_bytes),
        .file_done  (file_done)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    logic [7:0]       exp_q[$];
    logic [FAW+7:0]   obs_q[$];
    int bursts[$];
    int busy_runs[$];
    int done_cnt = 0, we_cnt = 0, run = 0, brun = 0;

    // Flash-side monitor: records every streamed byte and run lengths of fl_we / fl_busy.
    always @(negedge clk_in) begin
        if (rst) begin
            run = 0;
            brun = 0;
        end else begin
            if (fl_we) begin
                obs_q.push_back({fl_addr, fl_data});
                run++;
                we_cnt++;
            end else if (run > 0) begin
                bursts.push_back(run);
                run = 0;
            end
            if (fl_busy) brun++;
            else if (brun > 0) begin
                busy_runs.push_back(brun);
                brun = 0;
            end
            if (file_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Presents a command and returns once it will be accepted on the next edge;
    // halt_pre counts the halted cycles seen first (the previous word's halt window).
    task automatic send(input logic [1:0] cmd, input logic [31:0] d, input logic [3:0] be,
                        output int halt_pre);
        @(negedge clk_in);
        bus.m_cmd = cmd;
        bus.d_qual = 1'b1;
        bus.write_data = d;
        bus.write_be = be;
        halt_pre = 0;
        while (bus.s_halt !== 1'b0 && halt_pre < 200) begin
            @(negedge clk_in);
            halt_pre++;
        end
        if (halt_pre >= 200) check("accept_timeout", 64'(halt_pre), 64'd0);
    endtask

    task automatic release_bus();
        @(negedge clk_in);
        bus.d_qual = 1'b0;
        bus.m_cmd = CMD_NOP;
    endtask

    // Reference: enabled bytes MSB-first; a word that fills the page costs a drain plus program wait.
    task automatic model_write(input logic [31:0] d, input logic [3:0] be, output int pred_halt);
        int k;
        int pend;
        logic [31:0] w;
        k = $countones(be);
        pend = exp_q.size() % PB;
        pred_halt = k + ((k > 0 && pend + k >= PB) ? int'(PB + PC) : 0);
        w = d;
        for (int l = 3; l >= 0; l--)
            if (be[l]) exp_q.push_back(w[8*l +: 8]);
    endtask

    // After a CLOSE is presented: drop the bus and measure the halt through FLUSH..DONE.
    task automatic finish_close(input string tag);
        int h;
        int d0;
        int rem;
        d0 = done_cnt;
        rem = exp_q.size() % PB;
        @(negedge clk_in);
        bus.d_qual = 1'b0;
        bus.m_cmd = CMD_NOP;
        h = 0;
        while (bus.s_halt === 1'b1 && h < 400) begin
            @(negedge clk_in);
            h++;
        end
        check({tag, "_close_halt"}, 64'(h), 64'((rem > 0) ? rem + int'(PC) + 2 : 2));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic verify_file(input string tag);
        int n, full, rem, nb;
        n = exp_q.size();
        full = n / PB;
        rem = n % PB;
        nb = full + ((rem != 0) ? 1 : 0);
        check({tag, "_byte_count"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++)
            check({tag, "_addr_byte"}, 64'(obs_q[i]), 64'({FAW'(i), exp_q[i]}));
        check({tag, "_drain_count"}, 64'(bursts.size()), 64'(nb));
        for (int i = 0; i < nb && i < bursts.size(); i++)
            check({tag, "_drain_len"}, 64'(bursts[i]), 64'((i < full) ? int'(PB) : rem));
        check({tag, "_busy_count"}, 64'(busy_runs.size()), 64'(nb));
        for (int i = 0; i < busy_runs.size(); i++)
            check({tag, "_busy_len"}, 64'(busy_runs[i]), 64'(PC));
        check({tag, "_file_bytes"}, 64'(file_bytes), 64'(n));
        exp_q.delete();
        obs_q.delete();
        bursts.delete();
        busy_runs.delete();
    endtask

    initial begin
        int h, pred, c, n, we0, dn0;
        logic [31:0] d;
        logic [3:0]  be;

        bus.m_cmd = CMD_NOP;
        bus.d_qual = 1'b0;
        bus.write_data = '0;
        bus.write_be = '0;
        repeat (3) @(negedge clk_in);
        check("rst_s_halt", 64'(bus.s_halt), 64'd0);
        check("rst_fl_we", 64'(fl_we), 64'd0);
        check("rst_fl_addr", 64'(fl_addr), 64'd0);
        check("rst_fl_data", 64'(fl_data), 64'd0);
        check("rst_fl_busy", 64'(fl_busy), 64'd0);
        check("rst_file_bytes", 64'(file_bytes), 64'd0);
        check("rst_file_done", 64'(file_done), 64'd0);
        rst = 1'b0;

        // Single word
        send(CMD_OPEN, '0, '0, h);
        send(CMD_WRITE, 32'h1122_3344, 4'b1111, h);
        check("single_open_halt", 64'(h), 64'd0);
        model_write(32'h1122_3344, 4'b1111, pred);
        send(CMD_CLOSE, '0, '0, h);
        check("single_word_halt", 64'(h), 64'(pred));
        finish_close("single");
        check("single_file_bytes4", 64'(file_bytes), 64'd4);
        verify_file("single");

        // Sparse enables
        send(CMD_OPEN, '0, '0, h);
        send(CMD_WRITE, 32'hAABB_CCDD, 4'b1010, h);
        model_write(32'hAABB_CCDD, 4'b1010, pred);
        send(CMD_CLOSE, '0, '0, h);
        check("sparse_halt", 64'(h), 64'd2);
        finish_close("sparse");
        check("sparse_byte0", 64'(obs_q.size() > 0 ? obs_q[0][7:0] : 8'h00), 64'hAA);
        check("sparse_byte1", 64'(obs_q.size() > 1 ? obs_q[1][7:0] : 8'h00), 64'hCC);
        verify_file("sparse");

        // Ignored commands
        we0 = we_cnt;
        dn0 = done_cnt;
        send(CMD_WRITE, 32'hDEAD_BEEF, 4'b1111, h);
        send(CMD_CLOSE, '0, '0, h);
        release_bus();
        repeat (4) @(negedge clk_in);
        check("idle_ignored_halt", 64'(bus.s_halt), 64'd0);
        check("idle_ignored_we", 64'(we_cnt - we0), 64'd0);
        check("idle_ignored_done", 64'(done_cnt - dn0), 64'd0);
        send(CMD_OPEN, '0, '0, h);
        send(CMD_OPEN, '0, '0, h);
        send(CMD_WRITE, 32'h0102_0304, 4'b0000, h);
        release_bus();
        check("zero_be_no_halt", 64'(bus.s_halt), 64'd0);
        check("open_clears_bytes", 64'(file_bytes), 64'd0);
        check("ready_ignored_we", 64'(we_cnt - we0), 64'd0);

        // Page crossing in the same file: 2 + 4 + 4 bytes, page fills mid third word
        send(CMD_WRITE, 32'h0000_A1A2, 4'b0011, h);
        model_write(32'h0000_A1A2, 4'b0011, pred);
        send(CMD_WRITE, 32'hB1B2_B3B4, 4'b1111, h);
        check("cross_w1_halt", 64'(h), 64'(pred));
        model_write(32'hB1B2_B3B4, 4'b1111, pred);
        send(CMD_WRITE, 32'hC1C2_C3C4, 4'b1111, h);
        check("cross_w2_halt", 64'(h), 64'(pred));
        model_write(32'hC1C2_C3C4, 4'b1111, pred);
        send(CMD_CLOSE, '0, '0, h);
        check("cross_w3_halt", 64'(h), 64'(PB + PC + 4));
        finish_close("cross");
        check("cross_file_bytes10", 64'(file_bytes), 64'd10);
        check("cross_tail_addr", 64'(obs_q.size() > 8 ? obs_q[8][FAW+7:8] : '0), 64'd8);
        verify_file("cross");

        // Reset on the 3rd drain byte
        send(CMD_OPEN, '0, '0, h);
        send(CMD_WRITE, 32'h1111_1111, 4'b1111, h);
        send(CMD_WRITE, 32'h2222_2222, 4'b1111, h);
        release_bus();
        c = 0;
        n = 0;
        while (c < 3 && n < 100) begin
            if (fl_we === 1'b1) c++;
            if (c < 3) @(negedge clk_in);
            n++;
        end
        check("drain_reached", 64'(c), 64'd3);
        rst = 1'b1;
        @(negedge clk_in);
        check("mid_rst_fl_we", 64'(fl_we), 64'd0);
        check("mid_rst_s_halt", 64'(bus.s_halt), 64'd0);
        check("mid_rst_file_bytes", 64'(file_bytes), 64'd0);
        check("mid_rst_fl_busy", 64'(fl_busy), 64'd0);
        @(negedge clk_in);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        bursts.delete();
        busy_runs.delete();
        d = $urandom;
        send(CMD_OPEN, '0, '0, h);
        send(CMD_WRITE, d, 4'b1111, h);
        model_write(d, 4'b1111, pred);
        send(CMD_CLOSE, '0, '0, h);
        check("post_rst_halt", 64'(h), 64'(pred));
        finish_close("post_rst");
        verify_file("post_rst");

        // Back-to-back random words against the byte queue
        send(CMD_OPEN, '0, '0, h);
        pred = 0;
        for (int w = 0; w < 1000; w++) begin
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            send(CMD_WRITE, d, be, h);
            check("rand_halt_window", 64'(h), 64'(pred));
            model_write(d, be, pred);
        end
        send(CMD_CLOSE, '0, '0, h);
        check("rand_last_halt", 64'(h), 64'(pred));
        finish_close("rand");
        verify_file("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
